draw_column_slice: RTL and testbench



---
 rtl/draw_column_slice_pkg.sv | 22 ++
 rtl/draw_column_slice_slice_bounds.sv | 23 ++
 rtl/draw_column_slice.sv | 125 ++++++++++++
 tb/tb_draw_column_slice.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_column_slice_pkg.sv
// rtl/draw_column_slice_pkg.sv - shared screen geometry, colours and state encoding
package draw_column_slice_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int COLOUR_W     = 3;

  localparam logic [COLOUR_W-1:0] CEIL_COLOUR  = 3'b001;
  localparam logic [COLOUR_W-1:0] WALL_COLOUR  = 3'b100;
  localparam logic [COLOUR_W-1:0] FLOOR_COLOUR = 3'b010;
  localparam logic [COLOUR_W-1:0] SHADE_COLOUR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/draw_column_slice_slice_bounds.sv
// rtl/draw_column_slice_slice_bounds.sv - clamp slice height and centre it vertically
// Purely combinational; also reused by the texture stage.
module slice_bounds
  import draw_column_slice_pkg::*;
#(
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic [Y_W-1:0] slice_size_i,
  output logic [Y_W-1:0] h_o,
  output logic [Y_W-1:0] top_o,
  output logic [Y_W-1:0] bot_o
);

  localparam logic [Y_W-1:0] H_MAX = Y_W'(SCREEN_H);

  always_comb begin
    h_o   = (slice_size_i > H_MAX) ? H_MAX : slice_size_i;
    // Odd remainder truncates here, so the spare row lands below the wall.
    top_o = (H_MAX - h_o) >> 1;
    bot_o = top_o + h_o;
  end

endmodule

// File: rtl/draw_column_slice.sv
// rtl/draw_column_slice.sv - streams one raycast column (ceiling/wall/floor) to the VGA adapter
// Optional SHADE_SIDE_EN: vertical-wall hits draw the wall in SHADE_COLOUR.
module draw_column_slice
  import draw_column_slice_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [Y_W-1:0]      slice_size,
  input  logic [X_W-1:0]      column_x,
  input  logic                side_vert,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  state_t                state_q, state_d;
  logic [Y_W-1:0]        row_q, row_d;
  logic [X_W-1:0]        col_q;
  logic                  col_ok_q;
  logic [Y_W-1:0]        top_q, bot_q;
  logic [Y_W-1:0]        h_c, top_c, bot_c;
  logic                  accept, drawing_d;
  logic [COLOUR_W-1:0]   wall_c, colour_d;
  logic                  busy_q, done_q, plot_q;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [COLOUR_W-1:0]   colour_q;

  slice_bounds #(.SCREEN_H(SCREEN_H)) u_bounds (
    .slice_size_i (slice_size),
    .h_o          (h_c),
    .top_o        (top_c),
    .bot_o        (bot_c)
  );

`ifdef SHADE_SIDE_EN
  logic side_q;
  always_ff @(posedge clock) begin
    if (reset)       side_q <= 1'b0;
    else if (accept) side_q <= side_vert;
  end
  assign wall_c = side_q ? SHADE_COLOUR : WALL_COLOUR;
`else
  logic unused_side_vert;
  assign unused_side_vert = side_vert;
  assign wall_c = WALL_COLOUR;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_LOAD;
        accept  = 1'b1;
      end
      ST_LOAD: begin
        state_d = ST_DRAW;
        row_d   = '0;
      end
      ST_DRAW: begin
        row_d = row_q + 7'd1;
        if (row_q == Y_W'(SCREEN_H - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel outputs are computed from next-state values so they register in step with the row.
  always_comb begin
    drawing_d = (state_d == ST_DRAW);
    if (row_d < top_q)      colour_d = CEIL_COLOUR;
    else if (row_d < bot_q) colour_d = wall_c;
    else                    colour_d = FLOOR_COLOUR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      col_ok_q <= 1'b0;
      top_q    <= '0;
      bot_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (accept) begin
        col_q    <= column_x;
        col_ok_q <= (column_x < X_W'(SCREEN_W));
        top_q    <= top_c;
        bot_q    <= bot_c;
      end
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      plot_q   <= drawing_d && col_ok_q;
      x_q      <= drawing_d ? col_q : '0;
      y_q      <= drawing_d ? row_d : '0;
      colour_q <= drawing_d ? colour_d : '0;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign plot   = plot_q;
  assign x_out  = x_q;
  assign y_out  = y_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_draw_column_slice.sv
// tb/tb_draw_column_slice.sv - scoreboard bench for draw_column_slice
module tb_draw_column_slice;

  localparam int H = 120;
  localparam int W = 160;
`ifdef SHADE_SIDE_EN
  localparam bit SHADE = 1'b1;
`else
  localparam bit SHADE = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] slice_size;
  logic [7:0] column_x;
  logic       side_vert;
  logic       busy, done, plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pix, n_ceil, n_wall, n_floor;

  draw_column_slice dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .slice_size (slice_size),
    .column_x   (column_x),
    .side_vert  (side_vert),
    .busy       (busy),
    .done       (done),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour     (colour),
    .plot       (plot)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] model_colour(input int size, input int y, input int side);
    int h, top;
    h   = (size > H) ? H : size;
    top = (H - h) / 2;
    if (y < top)     return 3'b001;
    if (y < top + h) return (side != 0 && SHADE) ? 3'b110 : 3'b100;
    return 3'b010;
  endfunction

  task automatic push_column(input int size, input int col, input int side);
    pix_t p;
    if (col < W) begin
      for (int y = 0; y < H; y++) begin
        p.x = 8'(col);
        p.y = 7'(y);
        p.c = model_colour(size, y, side);
        exp_q.push_back(p);
      end
    end
  endtask

  always @(negedge clock) begin
    if (plot === 1'b1) begin
      n_pix++;
      if (colour === 3'b001) n_ceil++;
      else if (colour === 3'b100 || colour === 3'b110) n_wall++;
      else if (colour === 3'b010) n_floor++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d c=%b, required no pixel", x_out, y_out, colour);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        if ({x_out, y_out, colour} !== {e.x, e.y, e.c}) begin
          n_fail++;
          $display("FAIL pixel: got x=%0d y=%0d c=%b, required x=%0d y=%0d c=%b",
                   x_out, y_out, colour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic clear_counts();
    n_pix = 0; n_ceil = 0; n_wall = 0; n_floor = 0;
  endtask

  // Called at a negedge; drives start there (cycle 0) and follows the column to its done pulse.
  task automatic run_column(input int size, input int col, input int side, input int restart_at);
    int done_k;
    int exp_pix;
    exp_pix = (col < W) ? H : 0;
    push_column(size, col, side);
    clear_counts();
    slice_size = 7'(size); column_x = 8'(col); side_vert = side[0]; start = 1'b1;
    done_k = -1;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clock);
      if (k == 1) begin
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || plot !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL load_cycle: got busy=%b plot=%b done=%b, required 1 0 0", busy, plot, done);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (plot !== (exp_pix != 0)) begin
          n_fail++;
          $display("FAIL first_pixel_cycle: got plot=%b, required %b", plot, exp_pix != 0);
        end
      end
      if (restart_at != 0 && k == restart_at) begin
        start = 1'b1; column_x = 8'd20; slice_size = 7'd5;
      end
      if (restart_at != 0 && k == restart_at + 1) start = 1'b0;
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    n_checks++;
    if (done_k != H + 2) begin
      n_fail++;
      $display("FAIL done_cycle: got %0d, required %0d (-1 = timeout)", done_k, H + 2);
    end
    n_checks++;
    if (n_pix != exp_pix || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pixel_count: got %0d (left %0d), required %0d", n_pix, exp_q.size(), exp_pix);
      exp_q.delete();
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: got done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic check_split(input string name, input int c, input int w, input int f);
    n_checks++;
    if (n_ceil != c || n_wall != w || n_floor != f) begin
      n_fail++;
      $display("FAIL %s split: got ceil=%0d wall=%0d floor=%0d, required %0d %0d %0d",
               name, n_ceil, n_wall, n_floor, c, w, f);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; slice_size = '0; column_x = '0; side_vert = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({busy, done, plot, x_out, y_out, colour} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b plot=%b x=%0d y=%0d c=%b, required all 0",
               busy, done, plot, x_out, y_out, colour);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    run_column(40, 10, 0, 0);
    check_split("basic40", 40, 40, 40);
  endtask

  task automatic test_small_heights();
    run_column(0, 3, 0, 0);
    check_split("h0", 60, 0, 60);
    run_column(1, 4, 0, 0);
    check_split("h1", 59, 1, 60);
    run_column(33, 5, 0, 0);
    check_split("h33_odd", 43, 33, 44);
  endtask

  task automatic test_clamp();
    run_column(127, 6, 0, 0);
    check_split("h127", 0, 120, 0);
    run_column(120, 7, 0, 0);
    check_split("h120", 0, 120, 0);
  endtask

  task automatic test_mask();
    run_column(40, 200, 0, 0);
    run_column(40, 160, 0, 0);
    run_column(50, 159, 0, 0);
    check_split("x159", 35, 50, 35);
  endtask

  task automatic test_start_while_busy();
    run_column(40, 10, 0, 50);
    check_split("restart", 40, 40, 40);
  endtask

  task automatic test_shade();
    run_column(40, 10, 1, 0);
    check_split("side_vert", 40, 40, 40);
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = -1; d2 = -1;
    push_column(40, 10, 0);
    clear_counts();
    slice_size = 7'd40; column_x = 8'd10; side_vert = 1'b0; start = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1 = k;
          slice_size = 7'd80; column_x = 8'd30;
          push_column(80, 30, 0);
        end else begin
          d2 = k;
          break;
        end
      end
      if (k == 124) begin
        start = 1'b0;
        n_checks++;
        if (plot !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_load: got plot=%b busy=%b, required 0 1", plot, busy);
        end
      end
      if (k == 125) begin
        n_checks++;
        if (plot !== 1'b1 || y_out !== 7'd0 || x_out !== 8'd30) begin
          n_fail++;
          $display("FAIL b2b_first_pixel: got plot=%b x=%0d y=%0d, required 1 30 0", plot, x_out, y_out);
        end
      end
    end
    n_checks++;
    if (d1 != 122 || d2 != 245) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d/%0d, required 122/245", d1, d2);
    end
    n_checks++;
    if (n_pix != 240 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_pixels: got %0d (left %0d), required 240", n_pix, exp_q.size());
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_draw();
    push_column(40, 10, 0);
    clear_counts();
    slice_size = 7'd40; column_x = 8'd10; side_vert = 1'b0; start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got plot=%b busy=%b done=%b, required 0 0 0", plot, busy, done);
    end
    n_checks++;
    if (n_pix != 59) begin
      n_fail++;
      $display("FAIL reset_mid_pixels: got %0d, required 59", n_pix);
    end
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: got done=%b busy=%b, required 0 0", done, busy);
    end
    @(negedge clock);
    run_column(60, 45, 0, 0);
    check_split("after_reset", 30, 60, 30);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small_heights();
    test_clamp();
    test_mask();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_draw();
    test_shade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
